mole_round_ctrl: RTL
====================

# mole_round_ctrl

Round sequencer for the Whac-A-Mole game. Each round it fetches a one-hot hole position from the random-number block, lights that hole's LED for a fixed window, and judges the player's key presses. It keeps hit and miss scores and ends the game after a fixed number of rounds. It sits between the random generator, the key inputs and the LED/score display logic.

## Interface
- LED_W, 8: number of holes; width of the LED, key and random buses.
- ON_TICKS, 750: tick pulses a mole stays lit (≥1).
- GAP_TICKS, 250: tick pulses of dark time between moles (≥1).
- ROUNDS, 20: moles per game (1..255).
- clk, input, 1: system clock; every flop updates on its rising edge.
- rst, input, 1: reset, synchronous, active-low.
- tick, input, 1: one-clk timebase strobe; timers advance only on cycles with tick=1.
- start, input, 1: level; sampled only in IDLE and DONE.
- rnd_data, input, LED_W: one-hot value from the random generator.
- rnd_req, output, 1: one-cycle pulse asking for a new random value.
- key_n, input, LED_W: asynchronous active-low hole buttons, already debounced.
- mole_n, output, LED_W: active-low LED drive.
- score, output, 8: hit count, saturating at 255.
- miss, output, 8: miss count, saturating at 255.
- busy, output, 1: high in every state except IDLE and DONE.
- done, output, 1: high in DONE.

## Operation
- States: IDLE, REQ, SAMPLE, SHOW, GAP, DONE.
- Reset values:
  - state=IDLE, mole_n all ones, score=0, miss=0, rnd_req=0, busy=0, done=0.
  - Round counter, tick timer, retry counter and mole register are all 0.
- Reset asserted in any state takes effect at the next edge and overrides every other event.
- IDLE, or DONE, with start=1: clear score, miss and the round counter, then go to REQ.
- REQ:
  - rnd_req=1 for exactly this cycle, then go to SAMPLE.
- SAMPLE: latch rnd_data into the mole register.
  - A value that is not exactly one-hot goes back to REQ.
  - A retry limit of 3 applies to this case; on the fourth consecutive bad value, use bit 0.
  - Otherwise go to SHOW and clear the tick timer.
- SHOW:
  - mole_n = ~mole.
  - Hit: the falling-edge vector ANDed with mole is non-zero. Saturating score+1, then go to GAP.
  - Presses on other holes are ignored.
  - Timeout: the timer reaches ON_TICKS-1 on a tick. Saturating miss+1, then go to GAP.
  - A hit and a timeout in the same cycle count as a hit only.
- GAP:
  - mole_n all ones.
  - After GAP_TICKS ticks, increment the round counter.
  - When the counter reaches ROUNDS, go to DONE; otherwise go to REQ.
- DONE: score and miss hold until start or reset.
- start is ignored in REQ, SAMPLE, SHOW and GAP.

## Timing
- REQ to SAMPLE takes 1 clk. rnd_data must be valid in the cycle after the rnd_req pulse.
- SAMPLE to SHOW takes 1 clk.
- The mole is lit from the first edge after SAMPLE.
- The mole is lit for exactly ON_TICKS tick pulses; the first tick counted is the first tick while in SHOW.
- Key latency: 2-flop synchroniser plus edge register.
  - Edge E0 is the first edge that samples key_n low.
  - score and mole_n update at edge E2.
- Holding a key gives one hit only. A key already held when SHOW begins does not register.
- Counter width is 8 bits; increments at 255 keep 255.

## Configuration
- MOLE_NO_REPEAT_EN defined:
  - SAMPLE also rejects a value equal to the previous round's mole; this counts against the same retry limit.
  - After 3 rejects, rotate the previous mole left by one.
  - The previous-mole register resets to 0.
- Not defined: any one-hot value is accepted, and the previous-mole register is not built.

## Structure
- Package mole_pkg holds:
  - the state enum;
  - the constant for the 8-bit score width;
  - the constant for the retry limit (3);
  - a saturating-increment function.
- Sub-module mole_key_edge takes key_n and produces a per-bit, one-cycle falling-edge vector. It contains the 2-flop sync and the previous-value register, and is reset by rst.
- The timer and the FSM live in mole_round_ctrl.

## Test plan
- Reset, then start with rnd_data=8'h04, ON_TICKS=4, and no keys pressed.
  - Expect one rnd_req pulse, then mole_n=8'hFB for exactly 4 ticks, then miss=1 and score=0.
- Drive key_n[2] low during SHOW of mole 8'h04.
  - Expect score=1 and mole_n=8'hFF at the E2 edge, then GAP.
- Press key 5 during mole 8'h04.
  - Expect it ignored and a timeout miss; then press key 2 and hold it across the next mole 8'h04; expect no second hit.
- Feed rnd_data=8'h06, then 8'h00, then 8'h10.
  - Expect three rnd_req pulses and mole 8'h10.
  - With MOLE_NO_REPEAT_EN and a previous mole of 8'h10, expect further retries.
- Set ROUNDS=3 and let every mole time out.
  - Expect miss=3, done=1, busy=0.
  - A new start clears the counters and resumes.
- Assert rst during SHOW.
  - Expect mole_n=8'hFF, score=0, miss=0 and IDLE at the next edge.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared types and helpers for the mole round sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mole_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SAMPLE,
    S_SHOW,
    S_GAP,
    S_DONE
  } state_t;

  // Width of the score, miss and round counters.
  localparam int SCORE_W = 8;

  // Consecutive bad random values tolerated before a fallback mole is forced.
  localparam int RETRY_LIMIT = 3;
  localparam int RETRY_W     = $clog2(RETRY_LIMIT + 1);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mole_round_ctrl_if.sv
// Bundles the sequencer's game-side signals: random source, keys, LEDs, scores.
// Latency: none (wiring only).
// Backpressure: none; rnd_req is a one-cycle pulse answered one cycle later.
interface mole_round_ctrl_if #(
  parameter int LED_W = 8
);
  import mole_pkg::*;

  logic               tick;
  logic               start;
  logic [LED_W-1:0]   rnd_data;
  logic               rnd_req;
  logic [LED_W-1:0]   key_n;
  logic [LED_W-1:0]   mole_n;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] miss;
  logic               busy;
  logic               done;

  // The round controller.
  modport master (
    input  tick, start, rnd_data, key_n,
    output rnd_req, mole_n, score, miss, busy, done
  );

  // The surrounding game logic (random block, buttons, display).
  modport slave (
    output tick, start, rnd_data, key_n,
    input  rnd_req, mole_n, score, miss, busy, done
  );

endinterface

// File: rtl/mole_key_edge.sv
// Synchronises active-low buttons and flags each new press as a one-clk pulse.
// Latency: press sampled at edge E0 shows on fall after E1.
// Backpressure: none; a held key yields a single pulse.
module mole_key_edge #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] key_n,
  output logic [W-1:0] fall
);

  logic [W-1:0] sync1;
  logic [W-1:0] sync2;
  logic [W-1:0] prev;

  // Two-flop synchroniser followed by a history register; idle level is released (high).
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // High-to-low transition of the synchronised key.
  assign fall = prev & ~sync2;

endmodule

// File: rtl/mole_round_ctrl.sv
// Round sequencer: fetches a one-hot mole, lights it, judges presses, keeps score.
// Latency: REQ->SAMPLE->SHOW one clk each; key press scores at E2 (sync + edge).
// Backpressure: none; build option MOLE_NO_REPEAT_EN refuses back-to-back repeats.
module mole_round_ctrl
  import mole_pkg::*;
#(
  parameter int LED_W     = 8,
  parameter int ON_TICKS  = 750,
  parameter int GAP_TICKS = 250,
  parameter int ROUNDS    = 20
) (
  input  logic              clk,
  input  logic              rst,
  mole_round_ctrl_if.master bus
);

  // One timer serves both the lit window and the dark gap.
  localparam int T_MAX = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [TW-1:0]      ON_LAST   = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0]      GAP_LAST  = TW'(GAP_TICKS - 1);
  localparam logic [SCORE_W-1:0] ROUND_END = SCORE_W'(ROUNDS);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(RETRY_LIMIT);

  state_t             state_q, state_d;
  logic [LED_W-1:0]   mole_q, mole_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [SCORE_W-1:0] round_q, round_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] miss_q, miss_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               req;
  logic [LED_W-1:0]   fall;
  logic               rnd_bad;
  logic [LED_W-1:0]   fallback;
  logic [SCORE_W-1:0] round_inc;

  mole_key_edge #(
    .W (LED_W)
  ) u_key_edge (
    .clk   (clk),
    .rst   (rst),
    .key_n (bus.key_n),
    .fall  (fall)
  );

`ifdef MOLE_NO_REPEAT_EN
  logic [LED_W-1:0] prev_q;

  // Remember the mole accepted for the current round so the next one can refuse a repeat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q <= '0;
    end else if (state_q == S_SAMPLE && state_d == S_SHOW) begin
      prev_q <= mole_d;
    end
  end

  assign rnd_bad  = !$onehot(bus.rnd_data) || (bus.rnd_data == prev_q);
  // No previous mole yet (first round after reset) falls back to hole 0.
  assign fallback = (prev_q == '0) ? LED_W'(1) : {prev_q[LED_W-2:0], prev_q[LED_W-1]};
`else
  assign rnd_bad  = !$onehot(bus.rnd_data);
  assign fallback = LED_W'(1);
`endif

  assign round_inc = round_q + 1'b1;

  // State and datapath registers; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mole_q  <= '0;
      timer_q <= '0;
      round_q <= '0;
      score_q <= '0;
      miss_q  <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      mole_q  <= mole_d;
      timer_q <= timer_d;
      round_q <= round_d;
      score_q <= score_d;
      miss_q  <= miss_d;
      retry_q <= retry_d;
    end
  end

  // Next-state logic: round sequencing, mole selection, hit/timeout judging.
  always_comb begin
    state_d = state_q;
    mole_d  = mole_q;
    timer_d = timer_q;
    round_d = round_q;
    score_d = score_q;
    miss_d  = miss_q;
    retry_d = retry_q;
    req     = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          score_d = '0;
          miss_d  = '0;
          round_d = '0;
          retry_d = '0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        req     = 1'b1;
        state_d = S_SAMPLE;
      end

      S_SAMPLE: begin
        mole_d = bus.rnd_data;
        if (rnd_bad && retry_q != RETRY_MAX) begin
          retry_d = retry_q + 1'b1;
          state_d = S_REQ;
        end else begin
          if (rnd_bad) begin
            mole_d = fallback;
          end
          retry_d = '0;
          timer_d = '0;
          state_d = S_SHOW;
        end
      end

      S_SHOW: begin
        // A hit takes priority over a timeout landing on the same cycle.
        if ((fall & mole_q) != '0) begin
          score_d = sat_inc(score_q);
          timer_d = '0;
          state_d = S_GAP;
        end else if (bus.tick) begin
          if (timer_q == ON_LAST) begin
            miss_d  = sat_inc(miss_q);
            timer_d = '0;
            state_d = S_GAP;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end

      S_GAP: begin
        if (bus.tick) begin
          if (timer_q == GAP_LAST) begin
            timer_d = '0;
            round_d = round_inc;
            state_d = (round_inc == ROUND_END) ? S_DONE : S_REQ;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.rnd_req = req;
  assign bus.mole_n  = (state_q == S_SHOW) ? ~mole_q : '1;
  assign bus.score   = score_q;
  assign bus.miss    = miss_q;
  assign bus.busy    = !(state_q == S_IDLE || state_q == S_DONE);
  assign bus.done    = (state_q == S_DONE);

endmodule
